cla_mp_seq: RTL and testbench

- Multi-precision add/subtract sequencer built around one instance of the team's 32-bit `cla` adder (ports `a`, `b`, `cin`, `sum`; no carry output).
- Accepts WORDS×32-bit operands over a valid/ready handshake and feeds one 32-bit limb per cycle through the shared adder, LSB limb first.
- Chains the carry between limbs through a register and returns the full-width result over a valid/ready handshake.
- Serves as the wide-arithmetic unit for datapaths needing 64/128-bit add and sub without a wider adder.

---
 rtl/cla_mp_seq.sv | 153 +++++++++++++++
 tb/tb_cla_mp_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_mp_seq.sv
// Multi-precision add/subtract sequencer: WORDS x 32-bit limbs through one shared 32-bit cla.
// Optional flag outputs (zero, overflow) are enabled by defining CLA_MP_FLAGS_EN.

module cla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);
  logic [31:0] g;
  logic [31:0] p;

  assign g = a & b;
  assign p = a ^ b;

  // Generate/propagate carry evaluation, bit 0 upward.
  always_comb begin
    logic cc;
    sum = '0;
    cc  = cin;
    for (int i = 0; i < 32; i++) begin
      sum[i] = p[i] ^ cc;
      cc     = g[i] | (p[i] & cc);
    end
  end
endmodule

module cla_mp_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op_sub,
  input  logic [WORDS*32-1:0] a,
  input  logic [WORDS*32-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDS*32-1:0] sum,
  output logic                carry_out
`ifdef CLA_MP_FLAGS_EN
  ,
  output logic                zero,
  output logic                overflow
`endif
);
  localparam int unsigned W     = WORDS * 32;
  localparam int unsigned IDX_W = (WORDS > 2) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-33:0]    res_lo;
  logic             carry;
  logic [31:0]      limb_a;
  logic [31:0]      limb_b;
  logic [31:0]      limb_sum;
  logic             limb_cout;
  logic             last;
  logic             accept;
  logic [W-1:0]     full_res;

  assign limb_a   = a_reg[{idx, 5'd0} +: 32];
  assign limb_b   = b_reg[{idx, 5'd0} +: 32];
  assign last     = (idx == IDX_W'(WORDS - 1));
  assign accept   = in_valid && in_ready;
  assign full_res = {limb_sum, res_lo};

  cla u_cla (
    .a   (limb_a),
    .b   (limb_b),
    .cin (carry),
    .sum (limb_sum)
  );

  // Carry out of bit 31 recovered from the sum, since the cla exposes none.
  assign limb_cout = (limb_a[31] & limb_b[31]) |
                     ((limb_a[31] ^ limb_b[31]) & (limb_sum[31] ^ limb_a[31] ^ limb_b[31]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags follow the upcoming state so they are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_lo    <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef CLA_MP_FLAGS_EN
      zero      <= 1'b0;
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= a;
            b_reg <= op_sub ? ~b : b;
            carry <= op_sub;
            idx   <= '0;
          end
        end
        RUN: begin
          carry <= limb_cout;
          if (!last) begin
            res_lo[{idx, 5'd0} +: 32] <= limb_sum;
            idx <= idx + 1'b1;
          end else begin
            // Final limb: publish the full result and its flags together.
            sum       <= full_res;
            carry_out <= limb_cout;
`ifdef CLA_MP_FLAGS_EN
            zero      <= (full_res == '0);
            overflow  <= (a_reg[W-1] == b_reg[W-1]) && (limb_sum[31] != a_reg[W-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_mp_seq.sv
// Self-checking bench for cla_mp_seq (WORDS=4): directed table, random ops vs arithmetic model,
// backpressure and mid-operation reset sequences. Flag checks compile in with CLA_MP_FLAGS_EN.

module tb_cla_mp_seq;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = WORDS * 32;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         op_sub    = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         carry_out;
`ifdef CLA_MP_FLAGS_EN
  logic         zero;
  logic         overflow;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] s;
    logic         c;
    logic         z;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         z;
    logic         ov;
  } res_t;

  cla_mp_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef CLA_MP_FLAGS_EN
    .zero      (zero),
    .overflow  (overflow),
`endif
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Wide-integer reference: subtract is a + (2^W - 1 - b) + 1 in W+1 bits.
  function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic top);
    res_t         r;
    logic [W:0]   t;
    logic [W-1:0] bp;
    bp   = top ? ~tb2 : tb2;
    t    = {1'b0, ta} + {1'b0, bp} + (W + 1)'(top);
    r.s  = t[W-1:0];
    r.c  = t[W];
    r.z  = (t[W-1:0] == '0);
    r.ov = (ta[W-1] == bp[W-1]) && (t[W-1] != ta[W-1]);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic top);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue.in_ready", W'(in_ready), W'(1));
    a = ta; b = tb2; op_sub = top; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = rand_w(); b = rand_w(); op_sub = 1'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 30);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release.out_valid", W'(out_valid), W'(0));
    chk("release.in_ready", W'(in_ready), W'(1));
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                           input logic top, input res_t e);
    int lat;
    issue(ta, tb2, top);
    wait_result(lat);
    chk({tag, ".latency"}, W'(lat), W'(WORDS));
    chk({tag, ".sum"}, sum, e.s);
    chk({tag, ".carry"}, W'(carry_out), W'(e.c));
`ifdef CLA_MP_FLAGS_EN
    chk({tag, ".zero"}, W'(zero), W'(e.z));
    chk({tag, ".overflow"}, W'(overflow), W'(e.ov));
`endif
    release_out();
  endtask

  initial begin
    vec_t         tbl[7];
    res_t         e;
    logic [W-1:0] ta;
    logic [W-1:0] tb2;
    logic [W-1:0] held;
    logic         top;
    int           lat;

    tbl[0] = '{a: {W{1'b1}}, b: W'(1), op: 1'b0, s: '0, c: 1'b1, z: 1'b1, ov: 1'b0};
    tbl[1] = '{a: '0, b: W'(1), op: 1'b1, s: {W{1'b1}}, c: 1'b0, z: 1'b0, ov: 1'b0};
    tbl[2] = '{a: W'(5), b: W'(3), op: 1'b1, s: W'(2), c: 1'b1, z: 1'b0, ov: 1'b0};
    tbl[3] = '{a: W'(128'h0000_0000_FFFF_FFFF_FFFF_FFFF), b: W'(1), op: 1'b0,
               s: W'(128'h0000_0001_0000_0000_0000_0000), c: 1'b0, z: 1'b0, ov: 1'b0};
    tbl[4] = '{a: W'(7), b: W'(8), op: 1'b0, s: W'(15), c: 1'b0, z: 1'b0, ov: 1'b0};
    tbl[5] = '{a: W'(128'h1234_5678_9ABC_DEF0_0F0F_0F0F_0000_0001),
               b: W'(128'h1234_5678_9ABC_DEF0_0F0F_0F0F_0000_0001), op: 1'b1,
               s: '0, c: 1'b1, z: 1'b1, ov: 1'b0};
    tbl[6] = '{a: {1'b0, {(W-1){1'b1}}}, b: W'(1), op: 1'b0,
               s: {1'b1, {(W-1){1'b0}}}, c: 1'b0, z: 1'b0, ov: 1'b1};

    // Reset values are forced while rst is high.
    #2;
    chk("reset.in_ready", W'(in_ready), W'(0));
    chk("reset.out_valid", W'(out_valid), W'(0));
    chk("reset.sum", sum, '0);
    chk("reset.carry", W'(carry_out), W'(0));
`ifdef CLA_MP_FLAGS_EN
    chk("reset.zero", W'(zero), W'(0));
    chk("reset.overflow", W'(overflow), W'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release.ready_low", W'(in_ready), W'(0));
    @(posedge clk);
    #1;
    chk("release.ready_high", W'(in_ready), W'(1));

    for (int i = 0; i < 7; i++) begin
      e.s = tbl[i].s; e.c = tbl[i].c; e.z = tbl[i].z; e.ov = tbl[i].ov;
      run_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, e);
    end

    for (int i = 0; i < 40; i++) begin
      ta  = rand_w();
      tb2 = rand_w();
      top = 1'($urandom);
      case (i % 8)
        0: tb2 = ta;
        1: tb2 = ~ta;
        2: ta  = {W{1'b1}};
        default: ;
      endcase
      run_check($sformatf("rand%0d", i), ta, tb2, top, model(ta, tb2, top));
    end

    // Backpressure: result held 10 cycles, in_valid pulse must be ignored.
    ta  = W'(128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_FFFF);
    tb2 = W'(128'h0000_0001_1111_1111_2222_2222_3333_3333);
    e   = model(ta, tb2, 1'b0);
    issue(ta, tb2, 1'b0);
    wait_result(lat);
    chk("bp.latency", W'(lat), W'(WORDS));
    chk("bp.sum", sum, e.s);
    held = sum;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i == 3);
      @(posedge clk);
      #1;
      chk($sformatf("bp.valid%0d", i), W'(out_valid), W'(1));
      chk($sformatf("bp.ready%0d", i), W'(in_ready), W'(0));
      chk($sformatf("bp.stable%0d", i), sum, held);
    end
    in_valid = 1'b0;
    release_out();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp.idle_valid%0d", i), W'(out_valid), W'(0));
    end

    // Reset while RUN is processing limb 2.
    issue(W'(128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000), W'(128'h0001_0001_0001_0001_0001_0001_0001_0001), 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.in_ready", W'(in_ready), W'(0));
    chk("midrst.out_valid", W'(out_valid), W'(0));
    chk("midrst.sum", sum, '0);
    chk("midrst.carry", W'(carry_out), W'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst.ready_after", W'(in_ready), W'(1));
    run_check("midrst.add", W'(7), W'(8), 1'b0, model(W'(7), W'(8), 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
